// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// wb_arbiter
// Writeback arbiter feeding the register-file write port (we3/wa3/wd3).
// Single-cycle ALU results have absolute priority and no backpressure;
// long-latency results (mul/div/load) enter through a valid/ready handshake
// into a small circular FIFO and drain whenever the ALU leaves the slot free.
// Writes to r0 are dropped on both ports. One registered write per cycle.
//
// Optional feature: define WB_BYPASS_EN to let a long result skip the FIFO
// (latency 1) when the FIFO is empty and the ALU is idle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   alu_we/alu_wa/alu_wd ALU result (valid, dest reg, data)
//   lr_valid/lr_ready   long-result handshake (lr_ready combinational)
//   lr_wa/lr_wd         long-result dest reg and data
//   we3/wa3/wd3         registered regfile write port
//   fifo_count          entries currently buffered
//   alu_stall           registered request for one ALU bubble (starvation)
module wb_arbiter #(
  parameter int unsigned DEPTH      = 4,  // power of 2, >= 2
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_we,
  input  logic [4:0]                 alu_wa,
  input  logic [31:0]                alu_wd,
  input  logic                       lr_valid,
  output logic                       lr_ready,
  input  logic [4:0]                 lr_wa,
  input  logic [31:0]                lr_wd,
  output logic                       we3,
  output logic [4:0]                 wa3,
  output logic [31:0]                wd3,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       alu_stall
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = AW + DW;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  // FIFO storage and bookkeeping
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output and starvation registers
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  // Per-cycle decisions
  logic          alu_req;
  logic          fifo_empty;
  logic          push_hs;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [EW-1:0] head;

  // Request decode and handshake
  always_comb begin
    alu_req    = alu_we && (alu_wa != '0);
    fifo_empty = (count_q == '0);
    // Full blocks the handshake even if the head pops this cycle.
    lr_ready   = (count_q < CW'(DEPTH));
    push_hs    = lr_valid && lr_ready;
    pop        = !alu_req && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = fifo_empty && !alu_req && push_hs && (lr_wa != '0);
`else
    bypass     = 1'b0;
`endif
    // r0 results complete the handshake but are never stored.
    push       = push_hs && (lr_wa != '0) && !bypass;
    head       = mem_q[rptr_q];
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port selection: ALU, then FIFO head, then bypass; idle holds wa/wd
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (alu_req) begin
      we_d = 1'b1;
      wa_d = alu_wa;
      wd_d = alu_wd;
    end else if (pop) begin
      we_d = 1'b1;
      wa_d = head[EW-1:DW];
      wd_d = head[DW-1:0];
    end else if (bypass) begin
      we_d = 1'b1;
      wa_d = lr_wa;
      wd_d = lr_wd;
    end
  end

  // Starvation tracking: a non-empty FIFO that does not pop lost to the ALU
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
    // Stall tracks the saturated counter; it drops on the edge of the next pop.
    stall_d = (starve_d == SW'(STARVE_MAX));
  end

  // Control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Storage array: contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {lr_wa, lr_wd};
    end
  end

  assign we3        = we_q;
  assign wa3        = wa_q;
  assign wd3        = wd_q;
  assign fifo_count = count_q;
  assign alu_stall  = stall_q;

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    (count_q == CW'(DEPTH)) |-> !push);

endmodule
